// File: rtl/mmio_pkg.sv
// mmio_pkg
// Shared constants and types for the memory-mapped IO responder.
//   IO_BASE_DEFAULT          : word address of the first IO register
//   OFF_SW .. OFF_TIMER      : register offsets inside the 4-word IO window
//   DEBOUNCE_CYCLES_DEFAULT  : 10 ms at 25 MHz
//   db_state_t               : per-button debounce FSM states
package mmio_pkg;

   localparam logic [31:0] IO_BASE_DEFAULT         = 32'd4096;
   localparam int          DEBOUNCE_CYCLES_DEFAULT = 250000;

   localparam logic [1:0] OFF_SW      = 2'd0;
   localparam logic [1:0] OFF_LED     = 2'd1;
   localparam logic [1:0] OFF_BTN_EVT = 2'd2;
   localparam logic [1:0] OFF_TIMER   = 2'd3;

   typedef enum logic {
      DB_STABLE,
      DB_COUNTING
   } db_state_t;

endpackage

// File: rtl/mmio_btn_debounce.sv
// btn_debounce
// Single push-button conditioner: two-flop synchronizer feeding a
// STABLE/COUNTING debounce FSM. A new level is accepted only after the
// synchronized input has differed from the accepted level for
// DEBOUNCE_CYCLES consecutive cycles; any return to the accepted level
// restarts the count.
// Ports:
//   clock    in   system clock
//   reset    in   asynchronous, active-high reset
//   btn_raw  in   raw (asynchronous) button level
//   rise     out  one-cycle pulse on the cycle the accepted level goes 0->1
module btn_debounce
   import mmio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
)
(
   input  logic clock,
   input  logic reset,
   input  logic btn_raw,
   output logic rise
);

   localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic             debounced;
   logic             debounced_next;
   db_state_t        state;
   db_state_t        state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   // Two-flop synchronizer to bring the raw button into the clock domain.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= btn_raw;
         sync_2 <= sync_1;
      end
   end

   // FSM state, stability counter and accepted level.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= DB_STABLE;
         cnt       <= '0;
         debounced <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         debounced <= debounced_next;
      end
   end

   // Next-state logic. Entering COUNTING already accounts for the first
   // differing sample, so the commit happens on the DEBOUNCE_CYCLES-th one.
   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      debounced_next = debounced;
      rise           = 1'b0;
      case (state)
         DB_STABLE: begin
            if (sync_2 != debounced) begin
               state_next = DB_COUNTING;
               cnt_next   = CNT_W'(1);
            end
         end
         DB_COUNTING: begin
            if (sync_2 == debounced) begin
               state_next = DB_STABLE;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               state_next     = DB_STABLE;
               cnt_next       = '0;
               debounced_next = sync_2;
               rise           = sync_2;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_next = DB_STABLE;
            cnt_next   = '0;
         end
      endcase
   end

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder
// Responder on the processor data-memory bus. Decodes a 4-word IO window at
// IO_BASE (SW, LED, BTN_EVT, TIMER) and passes every other address through
// to RAM. Reads have one cycle of latency to match the synchronous RAM.
// Optional feature: define MMIO_TIMER_EN to build the 32-bit cycle timer at
// offset +3; without it that offset reads 0 and ignores writes.
// Ports:
//   clock         in   25 MHz system clock
//   reset         in   asynchronous, active-high reset
//   wren          in   processor store enable
//   address_dmem  in   processor data word address
//   data          in   processor store data
//   q_ram         in   RAM read data (1-cycle synchronous read)
//   q_dmem        out  read data returned to the processor
//   ram_wren      out  store enable forwarded to RAM (blocked for IO)
//   SW            in   raw slide switches
//   BTN           in   raw push buttons
//   LED           out  LED drive register
module mmio_responder
   import mmio_pkg::*;
#(
   parameter logic [31:0] IO_BASE         = IO_BASE_DEFAULT,
   parameter int          NUM_BTN         = 4,
   parameter int          DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
)
(
   input  logic               clock,
   input  logic               reset,
   input  logic               wren,
   input  logic [31:0]        address_dmem,
   input  logic [31:0]        data,
   input  logic [31:0]        q_ram,
   output logic [31:0]        q_dmem,
   output logic               ram_wren,
   input  logic [15:0]        SW,
   input  logic [NUM_BTN-1:0] BTN,
   output logic [15:0]        LED
);

   logic               io_hit;
   logic [1:0]         offset;
   logic               wr_io;
   logic               wr_led;
   logic               wr_evt;
   logic [15:0]        sw_sync_1;
   logic [15:0]        sw_sync_2;
   logic [NUM_BTN-1:0] btn_rise;
   logic [NUM_BTN-1:0] btn_evt;
   logic [31:0]        timer_value;
   logic [31:0]        rd_value;
   logic               rd_io_hit;
   logic [31:0]        rd_snapshot;
   logic               unused_data_hi;

   assign io_hit   = (address_dmem[31:2] == IO_BASE[31:2]);
   assign offset   = address_dmem[1:0];
   assign ram_wren = wren & ~io_hit;
   assign wr_io    = wren & io_hit;
   assign wr_led   = wr_io && (offset == OFF_LED);
   assign wr_evt   = wr_io && (offset == OFF_BTN_EVT);

   // The upper store-data bits never reach an IO register.
   assign unused_data_hi = ^data[31:16];

   // Switch synchronizer; software sees the second stage.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sw_sync_1 <= '0;
         sw_sync_2 <= '0;
      end else begin
         sw_sync_1 <= SW;
         sw_sync_2 <= sw_sync_1;
      end
   end

   // LED output register, loaded by stores to its offset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         LED <= '0;
      end else if (wr_led) begin
         LED <= data[15:0];
      end
   end

   // One debouncer per button.
   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clock   (clock),
         .reset   (reset),
         .btn_raw (BTN[i]),
         .rise    (btn_rise[i])
      );
   end

   // Sticky event flags: write-1-to-clear, but a press arriving in the same
   // cycle as its clear must not be lost, so the set is applied last.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         btn_evt <= '0;
      end else begin
         btn_evt <= (btn_evt & ~(wr_evt ? data[NUM_BTN-1:0] : '0)) | btn_rise;
      end
   end

`ifdef MMIO_TIMER_EN
   logic        wr_timer;
   logic [31:0] timer;

   assign wr_timer    = wr_io && (offset == OFF_TIMER);
   assign timer_value = timer;

   // Free-running cycle counter; a clearing store overrides the increment.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         timer <= '0;
      end else if (wr_timer) begin
         timer <= '0;
      end else begin
         timer <= timer + 32'd1;
      end
   end
`else
   assign timer_value = '0;
`endif

   // Select the addressed IO register for the read snapshot.
   always_comb begin
      rd_value = '0;
      case (offset)
         OFF_SW:      rd_value = {16'b0, sw_sync_2};
         OFF_LED:     rd_value = {16'b0, LED};
         OFF_BTN_EVT: rd_value = 32'(btn_evt);
         OFF_TIMER:   rd_value = timer_value;
         default:     rd_value = '0;
      endcase
   end

   // Read pipeline stage. The offset is consumed here by taking the snapshot,
   // so only the hit flag and the captured value need to be kept.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_io_hit   <= 1'b0;
         rd_snapshot <= '0;
      end else begin
         rd_io_hit   <= io_hit;
         rd_snapshot <= rd_value;
      end
   end

   assign q_dmem = rd_io_hit ? rd_snapshot : q_ram;

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder
// Scoreboard bench for mmio_responder. A reference model advances on each
// clock edge and queues the read data the DUT owes one cycle later; a
// separate monitor pops and compares on the falling edge. Build with or
// without MMIO_TIMER_EN to match the RTL.
module tb_mmio_responder;

   localparam int          NB   = 4;
   localparam int          DB   = 8;
   localparam logic [31:0] BASE = 32'd4096;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          wren = 1'b0;
   logic [31:0]   address_dmem = '0;
   logic [31:0]   data = '0;
   logic [31:0]   q_ram;
   logic [31:0]   q_dmem;
   logic          ram_wren;
   logic [15:0]   SW = '0;
   logic [NB-1:0] BTN = '0;
   logic [15:0]   LED;

   int compared   = 0;
   int mismatched = 0;

   mmio_responder #(
      .IO_BASE         (BASE),
      .NUM_BTN         (NB),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .wren         (wren),
      .address_dmem (address_dmem),
      .data         (data),
      .q_ram        (q_ram),
      .q_dmem       (q_dmem),
      .ram_wren     (ram_wren),
      .SW           (SW),
      .BTN          (BTN),
      .LED          (LED)
   );

   always #20 clock = ~clock;

   // Stand-in RAM with a 1-cycle synchronous read of fixed random contents.
   logic [31:0] ram_mem [64];
   always @(posedge clock or posedge reset) begin
      if (reset) q_ram <= '0;
      else       q_ram <= ram_mem[address_dmem[5:0]];
   end

   // Reference model state: what software should observe.
   logic [31:0]   sb [$];
   logic [15:0]   m_led = '0;
   logic [15:0]   m_sw1 = '0;
   logic [15:0]   m_sw2 = '0;
   logic [NB-1:0] m_b1 = '0;
   logic [NB-1:0] m_b2 = '0;
   logic [NB-1:0] m_deb = '0;
   logic [NB-1:0] m_flag = '0;
   int            m_run [NB];
   int unsigned   m_cyc = 0;
   int unsigned   m_base = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic inWindow(input logic [31:0] a);
      return (a >= BASE) && (a < BASE + 32'd4);
   endfunction

   task automatic modelReset();
      sb.delete();
      m_led  = '0;
      m_sw1  = '0;
      m_sw2  = '0;
      m_b1   = '0;
      m_b2   = '0;
      m_deb  = '0;
      m_flag = '0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
      m_cyc  = 0;
      m_base = 0;
   endtask

   // One clock edge of the model: queue the value the bus must return for
   // the address presented now, then advance the visible state.
   task automatic modelStep();
      logic [31:0]   off;
      logic [31:0]   exp;
      logic [NB-1:0] rises;
      m_cyc++;
      off = address_dmem - BASE;
      if (inWindow(address_dmem)) begin
         case (off)
            32'd0:   exp = {16'b0, m_sw2};
            32'd1:   exp = {16'b0, m_led};
            32'd2:   exp = 32'(m_flag);
`ifdef MMIO_TIMER_EN
            default: exp = m_cyc - m_base - 1;
`else
            default: exp = '0;
`endif
         endcase
      end else begin
         exp = ram_mem[address_dmem[5:0]];
      end
      sb.push_back(exp);

      // A level is accepted after DB consecutive synchronized samples differ.
      rises = '0;
      for (int i = 0; i < NB; i++) begin
         if (m_b2[i] != m_deb[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
               m_deb[i] = m_b2[i];
               m_run[i] = 0;
               rises[i] = m_b2[i];
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_b2  = m_b1;
      m_b1  = BTN;
      m_sw2 = m_sw1;
      m_sw1 = SW;

      if (wren && inWindow(address_dmem)) begin
         case (off)
            32'd1:   m_led = data[15:0];
            32'd2:   m_flag = m_flag & ~data[NB-1:0];
            32'd3:   m_base = m_cyc;
            default: ;
         endcase
      end
      m_flag = m_flag | rises;
   endtask

   always @(posedge clock or posedge reset) begin
      if (reset) modelReset();
      else       modelStep();
   end

   // Monitor: compare bus read data and the LED pins away from the edge.
   task automatic monitorStep();
      logic [31:0] exp;
      if (reset) begin
         checkOutput("reset_LED", {16'b0, LED}, 32'd0);
         checkOutput("reset_q_dmem", q_dmem, 32'd0);
      end else begin
         if (sb.size() > 0) begin
            exp = sb.pop_front();
            checkOutput("q_dmem", q_dmem, exp);
         end
         checkOutput("LED", {16'b0, LED}, {16'b0, m_led});
      end
   endtask

   always @(negedge clock) monitorStep();

   task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [15:0] sw, input logic [NB-1:0] btn);
      @(negedge clock);
      wren         = w;
      address_dmem = a;
      data         = d;
      SW           = sw;
      BTN          = btn;
      #1;
      checkOutput("ram_wren", {31'b0, ram_wren}, {31'b0, w && !inWindow(a)});
   endtask

   logic [15:0]   cur_sw;
   logic [NB-1:0] cur_btn;
   logic [31:0]   rnd_addr;

   task automatic randomPhase(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         case ($urandom_range(0, 5))
            0, 1, 2: rnd_addr = BASE + 32'($urandom_range(0, 3));
            3:       rnd_addr = BASE + 32'd1;
            4:       rnd_addr = 32'($urandom_range(0, 63));
            default: rnd_addr = ($urandom_range(0, 1) == 0) ? BASE - 32'd1 : BASE + 32'd4;
         endcase
         if ($urandom_range(0, 15) == 0) cur_sw = 16'($urandom);
         if ($urandom_range(0, 11) == 0) cur_btn[$urandom_range(0, NB - 1)] ^= 1'b1;
         applyStimulus($urandom_range(0, 3) == 0, rnd_addr, $urandom, cur_sw, cur_btn);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) ram_mem[i] = $urandom;
      cur_sw  = '0;
      cur_btn = '0;
      #5 reset = 1'b1;
      repeat (3) @(negedge clock);
      #2 reset = 1'b0;

      // LED store and readback.
      applyStimulus(1'b1, BASE + 32'd1, 32'h0000_A5A5, 16'h0000, 4'b0000);
      applyStimulus(1'b0, BASE + 32'd1, 32'h0, 16'h0000, 4'b0000);
      applyStimulus(1'b0, BASE + 32'd1, 32'h0, 16'h0000, 4'b0000);

      // RAM pass-through: store and load leave the LED alone.
      applyStimulus(1'b1, 32'd100, 32'h1234_5678, 16'h0000, 4'b0000);
      applyStimulus(1'b0, 32'd100, 32'h0, 16'h0000, 4'b0000);
      applyStimulus(1'b0, 32'd37, 32'h0, 16'h0000, 4'b0000);

      // Switch change observed through the synchronizer.
      for (int c = 0; c < 6; c++) applyStimulus(1'b0, BASE, 32'h0, 16'h8001, 4'b0000);

      // Bouncing BTN[0], then a steady press.
      for (int c = 0; c < 30; c++)
         applyStimulus(1'b0, BASE + 32'd2, 32'h0, 16'h8001, ((c / 3) % 2 == 0) ? 4'b0001 : 4'b0000);
      for (int c = 0; c < 16; c++) applyStimulus(1'b0, BASE + 32'd2, 32'h0, 16'h8001, 4'b0001);

      // BTN[1] press whose flag sets on the same edge as a W1C of bit 1.
      applyStimulus(1'b0, BASE + 32'd2, 32'h0, 16'h8001, 4'b0011);
      for (int c = 0; c < 8; c++) applyStimulus(1'b0, 32'd5, 32'h0, 16'h8001, 4'b0011);
      applyStimulus(1'b1, BASE + 32'd2, 32'h2, 16'h8001, 4'b0011);
      applyStimulus(1'b0, BASE + 32'd2, 32'h0, 16'h8001, 4'b0011);
      applyStimulus(1'b1, BASE + 32'd2, 32'h2, 16'h8001, 4'b0011);
      applyStimulus(1'b0, BASE + 32'd2, 32'h0, 16'h8001, 4'b0011);

      // Timer: two reads 10 cycles apart, then clear and re-read.
      applyStimulus(1'b0, BASE + 32'd3, 32'h0, 16'h8001, 4'b0011);
      for (int c = 0; c < 9; c++) applyStimulus(1'b0, 32'd9, 32'h0, 16'h8001, 4'b0011);
      applyStimulus(1'b0, BASE + 32'd3, 32'h0, 16'h8001, 4'b0011);
      applyStimulus(1'b1, BASE + 32'd3, 32'hFFFF_FFFF, 16'h8001, 4'b0011);
      for (int c = 0; c < 4; c++) applyStimulus(1'b0, BASE + 32'd3, 32'h0, 16'h8001, 4'b0011);

      cur_sw  = 16'h8001;
      cur_btn = 4'b0011;
      randomPhase(400);

      // Reset in the middle of a debounce.
      cur_btn = ~cur_btn;
      applyStimulus(1'b0, BASE + 32'd2, 32'h0, cur_sw, cur_btn);
      applyStimulus(1'b0, BASE + 32'd2, 32'h0, cur_sw, cur_btn);
      @(posedge clock);
      #5 reset = 1'b1;
      repeat (2) @(negedge clock);
      #2 reset = 1'b0;

      randomPhase(200);
      applyStimulus(1'b0, BASE + 32'd2, 32'h0, cur_sw, cur_btn);
      repeat (2) @(negedge clock);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
